// File: rtl/pipe_hazard_ctrl.sv
// Execute/Memory/Writeback control pipeline for a 5-stage ARM-style core:
// condition evaluation, flag register, forwarding selects and stall/flush generation.
module pipe_hazard_ctrl #(
    parameter int unsigned ALUCTRL_W = 2,
    parameter int unsigned RA_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           CondD,
    input  logic                 PCSD,
    input  logic                 RegWriteD,
    input  logic                 MemtoRegD,
    input  logic                 MemWriteD,
    input  logic                 BranchD,
    input  logic                 ALUSrcD,
    input  logic [ALUCTRL_W-1:0] ALUControlD,
    input  logic [1:0]           FlagWriteD,
    input  logic [RA_W-1:0]      RA1D,
    input  logic [RA_W-1:0]      RA2D,
    input  logic [RA_W-1:0]      WA3D,
    input  logic [3:0]           ALUFlags,
    output logic [ALUCTRL_W-1:0] ALUControlE,
    output logic                 ALUSrcE,
    output logic                 MemtoRegE,
    output logic                 MemWriteM,
    output logic                 RegWriteM,
    output logic                 RegWriteW,
    output logic                 MemtoRegW,
    output logic                 PCSrcW,
    output logic [RA_W-1:0]      WA3E,
    output logic [RA_W-1:0]      WA3M,
    output logic [RA_W-1:0]      WA3W,
    output logic                 BranchTakenE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [3:0]           FlagsQ
);

    // Execute stage registers
    logic                 pcs_e_q, reg_write_e_q, mem_to_reg_e_q, mem_write_e_q;
    logic                 branch_e_q, alu_src_e_q;
    logic [ALUCTRL_W-1:0] alu_ctrl_e_q;
    logic [1:0]           flag_write_e_q;
    logic [3:0]           cond_e_q;
    logic [RA_W-1:0]      ra1_e_q, ra2_e_q, wa3_e_q;

    // Memory and Writeback stage registers
    logic            pcsrc_m_q, reg_write_m_q, mem_write_m_q, mem_to_reg_m_q;
    logic [RA_W-1:0] wa3_m_q;
    logic            pcsrc_w_q, reg_write_w_q, mem_to_reg_w_q;
    logic [RA_W-1:0] wa3_w_q;
    logic [3:0]      flags_q;

    logic cond_ex_e, ld_stall, pc_wr_pending;
    logic flag_n, flag_z, flag_c, flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex_e = 1'b0;
        case (cond_e_q)
            4'b0000: cond_ex_e = flag_z;
            4'b0001: cond_ex_e = ~flag_z;
            4'b0010: cond_ex_e = flag_c;
            4'b0011: cond_ex_e = ~flag_c;
            4'b0100: cond_ex_e = flag_n;
            4'b0101: cond_ex_e = ~flag_n;
            4'b0110: cond_ex_e = flag_v;
            4'b0111: cond_ex_e = ~flag_v;
            4'b1000: cond_ex_e = flag_c & ~flag_z;
            4'b1001: cond_ex_e = ~flag_c | flag_z;
            4'b1010: cond_ex_e = ~(flag_n ^ flag_v);
            4'b1011: cond_ex_e = flag_n ^ flag_v;
            4'b1100: cond_ex_e = ~flag_z & ~(flag_n ^ flag_v);
            4'b1101: cond_ex_e = flag_z | (flag_n ^ flag_v);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    always_comb begin
        ForwardAE = 2'b00;
        if (reg_write_m_q && (ra1_e_q == wa3_m_q))      ForwardAE = 2'b10;
        else if (reg_write_w_q && (ra1_e_q == wa3_w_q)) ForwardAE = 2'b01;
        ForwardBE = 2'b00;
        if (reg_write_m_q && (ra2_e_q == wa3_m_q))      ForwardBE = 2'b10;
        else if (reg_write_w_q && (ra2_e_q == wa3_w_q)) ForwardBE = 2'b01;
    end

    assign BranchTakenE  = branch_e_q & cond_ex_e;
    assign ld_stall      = mem_to_reg_e_q & ((wa3_e_q == RA1D) | (wa3_e_q == RA2D));
    assign pc_wr_pending = PCSD | pcs_e_q | pcsrc_m_q;
    assign StallD        = ld_stall;
    assign StallF        = ld_stall | pc_wr_pending;
    assign FlushD        = pc_wr_pending | pcsrc_w_q | BranchTakenE;
    // A taken branch and a load-use stall together still bubble Execute.
    assign FlushE        = ld_stall | BranchTakenE;

    always_ff @(posedge clk) begin
        if (!reset || FlushE) begin
            pcs_e_q        <= 1'b0;
            reg_write_e_q  <= 1'b0;
            mem_to_reg_e_q <= 1'b0;
            mem_write_e_q  <= 1'b0;
            branch_e_q     <= 1'b0;
            alu_src_e_q    <= 1'b0;
            alu_ctrl_e_q   <= '0;
            flag_write_e_q <= 2'b00;
            cond_e_q       <= 4'b0000;
            ra1_e_q        <= '0;
            ra2_e_q        <= '0;
            wa3_e_q        <= '0;
        end else begin
            pcs_e_q        <= PCSD;
            reg_write_e_q  <= RegWriteD;
            mem_to_reg_e_q <= MemtoRegD;
            mem_write_e_q  <= MemWriteD;
            branch_e_q     <= BranchD;
            alu_src_e_q    <= ALUSrcD;
            alu_ctrl_e_q   <= ALUControlD;
            flag_write_e_q <= FlagWriteD;
            cond_e_q       <= CondD;
            ra1_e_q        <= RA1D;
            ra2_e_q        <= RA2D;
            wa3_e_q        <= WA3D;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pcsrc_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            mem_to_reg_m_q <= 1'b0;
            wa3_m_q        <= '0;
            pcsrc_w_q      <= 1'b0;
            reg_write_w_q  <= 1'b0;
            mem_to_reg_w_q <= 1'b0;
            wa3_w_q        <= '0;
            flags_q        <= 4'b0000;
        end else begin
            pcsrc_m_q      <= pcs_e_q & cond_ex_e;
            reg_write_m_q  <= reg_write_e_q & cond_ex_e;
            mem_write_m_q  <= mem_write_e_q & cond_ex_e;
            mem_to_reg_m_q <= mem_to_reg_e_q;
            wa3_m_q        <= wa3_e_q;
            pcsrc_w_q      <= pcsrc_m_q;
            reg_write_w_q  <= reg_write_m_q;
            mem_to_reg_w_q <= mem_to_reg_m_q;
            wa3_w_q        <= wa3_m_q;
            if (flag_write_e_q[1] && cond_ex_e) flags_q[3:2] <= ALUFlags[3:2];
            if (flag_write_e_q[0] && cond_ex_e) flags_q[1:0] <= ALUFlags[1:0];
        end
    end

    assign ALUControlE = alu_ctrl_e_q;
    assign ALUSrcE     = alu_src_e_q;
    assign MemtoRegE   = mem_to_reg_e_q;
    assign WA3E        = wa3_e_q;
    assign MemWriteM   = mem_write_m_q;
    assign RegWriteM   = reg_write_m_q;
    assign WA3M        = wa3_m_q;
    assign RegWriteW   = reg_write_w_q;
    assign MemtoRegW   = mem_to_reg_w_q;
    assign PCSrcW      = pcsrc_w_q;
    assign WA3W        = wa3_w_q;
    assign FlagsQ      = flags_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: condition table, directed hazard sequences and a
// randomized run against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       pcs, rw, mtr, mw, br, alusrc;
        logic [1:0] aluctl, fw;
        logic [3:0] cond, ra1, ra2, wa3;
    } ins_t;

    typedef struct packed {
        logic       pcsrc, rw, mw, mtr;
        logic [3:0] wa3;
    } mw_t;

    typedef struct {
        logic [3:0] flags;
        logic [3:0] cond;
        logic       taken;
    } cv_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    ins_t       d_in = '0;
    logic [3:0] alu_flags = 4'h0;

    logic [1:0] alu_ctrl_e, fwd_a, fwd_b;
    logic       alu_src_e, mtr_e, mw_m, rw_m, rw_w, mtr_w, pcsrc_w;
    logic [3:0] wa3_e, wa3_m, wa3_w, flags_q;
    logic       bt_e, stall_f, stall_d, flush_d, flush_e;

    int checks = 0;
    int errors = 0;

    // Reference model state: one instruction record per stage plus flags.
    ins_t       me = '0;
    mw_t        mm = '0;
    mw_t        mwb = '0;
    logic [3:0] mflags = 4'h0;

    pipe_hazard_ctrl #(.ALUCTRL_W(2), .RA_W(4)) dut (
        .clk(clk), .reset(reset),
        .CondD(d_in.cond), .PCSD(d_in.pcs), .RegWriteD(d_in.rw), .MemtoRegD(d_in.mtr),
        .MemWriteD(d_in.mw), .BranchD(d_in.br), .ALUSrcD(d_in.alusrc),
        .ALUControlD(d_in.aluctl), .FlagWriteD(d_in.fw),
        .RA1D(d_in.ra1), .RA2D(d_in.ra2), .WA3D(d_in.wa3), .ALUFlags(alu_flags),
        .ALUControlE(alu_ctrl_e), .ALUSrcE(alu_src_e), .MemtoRegE(mtr_e),
        .MemWriteM(mw_m), .RegWriteM(rw_m), .RegWriteW(rw_w), .MemtoRegW(mtr_w),
        .PCSrcW(pcsrc_w), .WA3E(wa3_e), .WA3M(wa3_m), .WA3W(wa3_w),
        .BranchTakenE(bt_e), .StallF(stall_f), .StallD(stall_d), .FlushD(flush_d),
        .FlushE(flush_e), .ForwardAE(fwd_a), .ForwardBE(fwd_b), .FlagsQ(flags_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return !c[0];
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [63:0] obs_vec();
        return {30'd0, alu_ctrl_e, alu_src_e, mtr_e, mw_m, rw_m, rw_w, mtr_w, pcsrc_w,
                wa3_e, wa3_m, wa3_w, bt_e, stall_f, stall_d, flush_d, flush_e,
                fwd_a, fwd_b, flags_q};
    endfunction

    function automatic logic [63:0] exp_vec();
        bit cx, bt, lds, pend;
        logic [1:0] fa, fb;
        cx   = cond_holds(me.cond, mflags);
        bt   = me.br && cx;
        lds  = me.mtr && (me.wa3 == d_in.ra1 || me.wa3 == d_in.ra2);
        pend = d_in.pcs || me.pcs || mm.pcsrc;
        fa = (mm.rw && me.ra1 == mm.wa3) ? 2'd2 : (mwb.rw && me.ra1 == mwb.wa3) ? 2'd1 : 2'd0;
        fb = (mm.rw && me.ra2 == mm.wa3) ? 2'd2 : (mwb.rw && me.ra2 == mwb.wa3) ? 2'd1 : 2'd0;
        return {30'd0, me.aluctl, me.alusrc, me.mtr, mm.mw, mm.rw, mwb.rw, mwb.mtr, mwb.pcsrc,
                me.wa3, mm.wa3, mwb.wa3, bt, lds || pend, lds, pend || mwb.pcsrc || bt,
                lds || bt, fa, fb, mflags};
    endfunction

    // Advance one clock; the model consumes the inputs present before the edge.
    task automatic tick();
        ins_t ne;
        mw_t nm, nw;
        logic [3:0] nf;
        bit cx, lds;
        cx  = cond_holds(me.cond, mflags);
        lds = me.mtr && (me.wa3 == d_in.ra1 || me.wa3 == d_in.ra2);
        if (!reset) begin
            ne = '0; nm = '0; nw = '0; nf = 4'h0;
        end else begin
            nw = mm;
            nm.pcsrc = me.pcs && cx;
            nm.rw    = me.rw && cx;
            nm.mw    = me.mw && cx;
            nm.mtr   = me.mtr;
            nm.wa3   = me.wa3;
            nf = mflags;
            if (me.fw[1] && cx) nf[3:2] = alu_flags[3:2];
            if (me.fw[0] && cx) nf[1:0] = alu_flags[1:0];
            ne = (lds || (me.br && cx)) ? '0 : d_in;
        end
        @(posedge clk);
        #1;
        me = ne; mm = nm; mwb = nw; mflags = nf;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        d_in  = '0;
        tick();
        tick();
        reset = 1'b1;
        settle();
    endtask

    cv_t tbl[16];

    initial begin
        tbl[0]  = '{4'b0100, 4'b0000, 1'b1};
        tbl[1]  = '{4'b0100, 4'b0001, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0010, 1'b1};
        tbl[3]  = '{4'b0000, 4'b0011, 1'b1};
        tbl[4]  = '{4'b1000, 4'b0100, 1'b1};
        tbl[5]  = '{4'b1000, 4'b0101, 1'b0};
        tbl[6]  = '{4'b0001, 4'b0110, 1'b1};
        tbl[7]  = '{4'b0001, 4'b0111, 1'b0};
        tbl[8]  = '{4'b0010, 4'b1000, 1'b1};
        tbl[9]  = '{4'b0110, 4'b1001, 1'b1};
        tbl[10] = '{4'b1001, 4'b1010, 1'b1};
        tbl[11] = '{4'b1000, 4'b1011, 1'b1};
        tbl[12] = '{4'b0000, 4'b1100, 1'b1};
        tbl[13] = '{4'b0100, 4'b1101, 1'b1};
        tbl[14] = '{4'b0000, 4'b1110, 1'b1};
        tbl[15] = '{4'b1111, 4'b1111, 1'b0};

        // Reset state
        do_reset();
        chk("reset_outputs", obs_vec(), 64'd0);
        chk("reset_forward", {60'd0, fwd_a, fwd_b}, 64'd0);

        // Condition codes via a flag write followed by a branch
        for (int i = 0; i < 16; i++) begin
            d_in = '0; d_in.fw = 2'b11; d_in.cond = 4'b1110;
            settle(); tick();
            d_in = '0; d_in.br = 1'b1; d_in.cond = tbl[i].cond;
            alu_flags = tbl[i].flags;
            settle(); tick();
            d_in = '0;
            settle();
            chk($sformatf("cond_%0d_flags", i), {60'd0, flags_q}, {60'd0, tbl[i].flags});
            chk($sformatf("cond_%0d_taken", i), {63'd0, bt_e}, {63'd0, tbl[i].taken});
            tick();
        end

        // Load-use stall then Writeback forwarding
        do_reset();
        d_in = '0; d_in.rw = 1; d_in.mtr = 1; d_in.cond = 4'b1110; d_in.wa3 = 4'd2;
        d_in.ra1 = 4'd1;
        settle(); tick();
        d_in = '0; d_in.rw = 1; d_in.cond = 4'b1110; d_in.ra1 = 4'd2; d_in.ra2 = 4'd7;
        d_in.wa3 = 4'd4;
        settle();
        chk("lu_stall", {61'd0, stall_f, stall_d, flush_e}, 64'b111);
        tick(); settle();
        chk("lu_bubble", {61'd0, mtr_e, stall_d, flush_e}, 64'd0);
        chk("lu_bubble_wa3", {60'd0, wa3_e}, 64'd0);
        tick(); settle();
        chk("lu_forward_a", {62'd0, fwd_a}, 64'd1);
        chk("lu_dep_in_e", {60'd0, wa3_e}, 64'd4);

        // Memory result beats Writeback result
        do_reset();
        d_in = '0; d_in.rw = 1; d_in.cond = 4'b1110; d_in.wa3 = 4'd3;
        settle(); tick(); settle(); tick();
        d_in = '0; d_in.cond = 4'b1110; d_in.ra1 = 4'd3; d_in.ra2 = 4'd3;
        settle(); tick(); d_in = '0; settle();
        chk("fwd_mem_wins", {60'd0, fwd_a, fwd_b}, 64'b1010);

        // Conditional skip: NE with Z set
        do_reset();
        d_in = '0; d_in.fw = 2'b11; d_in.cond = 4'b1110;
        settle(); tick();
        alu_flags = 4'b0100;
        d_in = '0; d_in.rw = 1; d_in.fw = 2'b11; d_in.cond = 4'b0001; d_in.wa3 = 4'd6;
        settle(); tick();
        alu_flags = 4'b1111; d_in = '0;
        settle(); tick(); settle();
        chk("skip_regwrite_m", {63'd0, rw_m}, 64'd0);
        chk("skip_flags_hold", {60'd0, flags_q}, 64'b0100);

        // Split flag write: only N,Z updated
        do_reset();
        d_in = '0; d_in.fw = 2'b10; d_in.cond = 4'b1110;
        settle(); tick();
        d_in = '0; alu_flags = 4'b1011;
        settle(); tick(); settle();
        chk("flag_split", {60'd0, flags_q}, 64'b1000);

        // Taken branch squashes the instruction behind it
        do_reset();
        d_in = '0; d_in.br = 1; d_in.cond = 4'b1110;
        settle(); tick();
        d_in = '0; d_in.rw = 1; d_in.mtr = 1; d_in.alusrc = 1; d_in.aluctl = 2'b11;
        d_in.br = 1; d_in.cond = 4'b1110; d_in.wa3 = 4'd5;
        settle();
        chk("br_taken", {61'd0, bt_e, flush_d, flush_e}, 64'b111);
        tick(); d_in = '0; settle();
        chk("br_e_zero", {55'd0, alu_ctrl_e, alu_src_e, mtr_e, wa3_e, bt_e}, 64'd0);

        // PC write walks D, E, M, W; reset then clears PCSrcW
        do_reset();
        d_in = '0; d_in.pcs = 1; d_in.cond = 4'b1110;
        settle();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("pcw_stallf_%0d", c), {63'd0, stall_f}, {63'd0, c < 3});
            chk($sformatf("pcw_flushd_%0d", c), {63'd0, flush_d}, 64'd1);
            if (c < 3) begin
                tick(); d_in = '0; settle();
            end
        end
        chk("pcw_pcsrc_w", {63'd0, pcsrc_w}, 64'd1);
        reset = 1'b0;
        tick(); settle();
        chk("pcw_reset_clear", {62'd0, pcsrc_w, flush_d}, 64'd0);
        reset = 1'b1;

        // Randomized run against the model, with occasional mid-stream resets
        for (int n = 0; n < 400; n++) begin
            d_in.pcs    = ($urandom_range(0, 7) == 0);
            d_in.rw     = $urandom_range(0, 1);
            d_in.mtr    = ($urandom_range(0, 2) == 0);
            d_in.mw     = $urandom_range(0, 1);
            d_in.br     = ($urandom_range(0, 5) == 0);
            d_in.alusrc = $urandom_range(0, 1);
            d_in.aluctl = 2'($urandom_range(0, 3));
            d_in.fw     = 2'($urandom_range(0, 3));
            d_in.cond   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b1110;
            d_in.ra1    = 4'($urandom_range(0, 3));
            d_in.ra2    = 4'($urandom_range(0, 3));
            d_in.wa3    = 4'($urandom_range(0, 3));
            alu_flags   = 4'($urandom_range(0, 15));
            reset       = ($urandom_range(0, 29) != 0);
            settle();
            chk($sformatf("model_cycle_%0d", n), obs_vec(), exp_vec());
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 2, meaning the ALU control field width carried to Execute.
REQ-002 SHALL have parameter RA_W, default 4, meaning the register address width used for hazard and forwarding compares.
REQ-003 SHALL have ports in this order, clock and reset first:
- clk  in  1  single clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- CondD  in  4  condition field of the Decode-stage instruction.
- PCSD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoded Decode-stage controls.
- ALUControlD  in  ALUCTRL_W  decoded ALU operation.
- FlagWriteD  in  2  bit1 enables N,Z update; bit0 enables C,V update.
- RA1D, RA2D, WA3D  in  RA_W each  Decode-stage source and destination registers.
- ALUFlags  in  4  {N,Z,C,V} from the Execute-stage ALU.
- ALUControlE  out  ALUCTRL_W.
- ALUSrcE, MemtoRegE  out  1 each.
- MemWriteM, RegWriteM  out  1 each.
- RegWriteW, MemtoRegW, PCSrcW  out  1 each.
- WA3E, WA3M, WA3W  out  RA_W each.
- BranchTakenE  out  1  taken branch resolved in Execute.
- StallF, StallD, FlushD, FlushE  out  1 each  hazard controls.
- ForwardAE, ForwardBE  out  2 each  operand mux selects: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- FlagsQ  out  4  architectural flags register.

Function
REQ-004 SHALL register all D controls plus CondD, RA1D, RA2D and WA3D into Execute on each edge; when FlushE=1, SHALL load zeros into the Execute registers (bubble).
REQ-005 SHALL register the E-to-M controls (PCSrc, RegWrite, MemWrite, MemtoReg, WA3) and the M-to-W controls (PCSrc, RegWrite, MemtoReg, WA3) every cycle without stall or flush.
REQ-006 SHALL compute CondExE combinationally from CondE and FlagsQ for all 15 ARM conditions EQ..AL; code 1111 SHALL evaluate false.
REQ-007 SHALL gate RegWrite, MemWrite and PCS in Execute with CondExE before they enter Memory; PCSrcE = PCSE & CondExE.
REQ-008 SHALL set BranchTakenE = BranchE & CondExE.
REQ-009 SHALL update FlagsQ[3:2] from ALUFlags[3:2] when FlagWriteE[1] & CondExE, and FlagsQ[1:0] from ALUFlags[1:0] when FlagWriteE[0] & CondExE; otherwise FlagsQ SHALL hold.
REQ-010 SHALL set ForwardAE=10 if RegWriteM & (RA1E==WA3M), else 01 if RegWriteW & (RA1E==WA3W), else 00; the Memory match SHALL win when both match. ForwardBE uses RA2E in the same way.
REQ-011 SHALL set LdStall = MemtoRegE & ((WA3E==RA1D) | (WA3E==RA2D)).
REQ-012 SHALL set PCWrPending = PCSD | PCSE | PCSrcM.
REQ-013 SHALL drive StallD = LdStall and StallF = LdStall | PCWrPending.
REQ-014 SHALL drive FlushD = PCWrPending | PCSrcW | BranchTakenE and FlushE = LdStall | BranchTakenE.
REQ-015 On a simultaneous LdStall and BranchTakenE, SHALL still assert FlushE so that the bubble replaces the stalled instruction; StallD may be 1 and FlushD=1 takes effect externally.
REQ-016 SHALL implement all hazard and forwarding outputs combinationally from the current pipeline registers, with zero-cycle latency.

Reset
REQ-017 While reset=0 at a rising edge, SHALL clear all E, M and W pipeline registers and FlagsQ to 0.
REQ-018 With the pipeline registers cleared, all outputs SHALL be 0, and ForwardAE/BE=00.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight instructions in one edge, and no pending write SHALL survive.

Verification
REQ-020 Load-use: LDR R2 in E (MemtoRegE=1, WA3E=2) with RA1D=2 -> StallF=1, StallD=1, FlushE=1; the next cycle has a bubble in E and ForwardAE=01 when the dependent instruction reaches E.
REQ-021 Forwarding: ADD to R3 in M, and RA1E=RA2E=3, and R3 also in W -> ForwardAE=ForwardBE=10.
REQ-022 Conditional skip: FlagsQ=0100 (Z=1) and CondE=0001 (NE) with RegWriteE=1 -> RegWriteM=0 the next cycle and FlagsQ unchanged.
REQ-023 Flag split: FlagWriteE=10, CondE=1110, ALUFlags=1011, FlagsQ=0000 -> FlagsQ=1000 after the edge.
REQ-024 Branch: BranchE=1, CondE=1110 -> BranchTakenE=1, FlushD=1, FlushE=1; the next-cycle Execute registers are all zero.
REQ-025 PC write: PCSD=1 held one cycle -> StallF=1 for 3 cycles (D, E, M) and FlushD=1 for 4 cycles (including PCSrcW); then reset=0 mid-sequence clears PCSrcW on the next edge.
